display_scan_ctrl: RTL and testbench

- Time-multiplexed 7-segment scan controller.
- Replaces the free-running clock on the 2:1 number-select line with a full N-digit scheduler.
- Holds double-buffered digit values and steps through the digits at a programmable refresh rate.
- Presents the selected 4-bit digit code on SA (feeds the BCD decoder) and drives per-digit active-low anode enables with dead-time blanking between digits to suppress ghosting.

---
 rtl/display_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 7-segment scan controller.
//
// Steps through NUM_DIGITS digit slots of PRESC_DIV clocks each. Every slot
// opens with DEAD_CYC blanked cycles and then drives that digit's anode
// (active-low) for the rest of the slot. Digit codes are double-buffered.
// LOAD writes the shadow register. The shadow is committed to the active
// register only at a frame wrap, so a frame never shows a mix of old and new
// data.
//
// Optional build macro LZ_BLANK_EN: leading-zero blanking. When it is defined,
// a digit is not driven if it and every higher digit are zero. Digit 0 is
// always driven.
//
// Ports:
//   CLK      system clock, rising edge
//   RST      synchronous reset, active-high
//   EN       scan enable; low freezes the scan and blanks the anodes
//   LOAD     single-cycle strobe that captures VAL into the shadow register
//   VAL      packed digit codes; digit i = VAL[4i+3:4i]
//   SA       code of the digit currently scanned (SA[3] = W)
//   AN       anode enables, active-low, at most one low at a time
//   DIG_IDX  index of the current slot
//   PEND     shadow holds data that has not been committed yet
//   FRAME    one-cycle pulse when the index wraps from the last slot to 0
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESC_DIV  = 50000,
  parameter int unsigned DEAD_CYC   = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          EN,
  input  logic                          LOAD,
  input  logic [4*NUM_DIGITS-1:0]       VAL,
  output logic [3:0]                    SA,
  output logic [NUM_DIGITS-1:0]         AN,
  output logic [$clog2(NUM_DIGITS)-1:0] DIG_IDX,
  output logic                          PEND,
  output logic                          FRAME
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W  = $clog2(PRESC_DIV);
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic                pend_q, pend_d;
  logic                frame_q, frame_d;
  logic [3:0]          sa_q, sa_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                slot_end;
  logic                last_slot;
  logic                commit;
  logic [NUM_DIGITS-1:0] drive_ok;

  assign slot_end  = (cnt_q == CNT_W'(PRESC_DIV - 1));
  assign last_slot = (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Per-digit permission to drive the anode. Leading-zero blanking
  // suppresses a digit whose own code and all higher codes are zero.
  always_comb begin
    drive_ok = '1;
`ifdef LZ_BLANK_EN
    begin
      logic nz_chain;
      nz_chain = 1'b0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
        nz_chain    = nz_chain | (active_q[4*i +: 4] != 4'd0);
        drive_ok[i] = nz_chain;
      end
    end
`endif
  end

  // Next-state logic for prescaler, slot FSM, buffers and outputs.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    frame_d  = 1'b0;
    commit   = 1'b0;

    if (EN) begin
      cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);

      unique case (state_q)
        ST_BLANK: if (cnt_q == CNT_W'(DEAD_CYC - 1)) state_d = ST_DRIVE;
        ST_DRIVE: if (slot_end)                      state_d = ST_BLANK;
        default:                                     state_d = ST_BLANK;
      endcase

      if (slot_end) begin
        idx_d   = last_slot ? '0 : idx_q + IDX_W'(1);
        frame_d = last_slot;
        commit  = last_slot & pend_q;
      end
    end

    // The commit takes the pre-edge shadow. A LOAD on the same edge refills
    // the shadow and re-arms PEND for the next wrap.
    if (commit) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
    if (LOAD) begin
      shadow_d = VAL;
      pend_d   = 1'b1;
    end

    // SA follows the slot index, so it settles before the anode turns on.
    sa_d = 4'd0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_d == IDX_W'(i)) sa_d = active_d[4*i +: 4];
    end

    an_d = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (EN && (state_d == ST_DRIVE) && (idx_d == IDX_W'(i)) && drive_ok[i]) begin
        an_d[i] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      frame_q  <= 1'b0;
      sa_q     <= 4'd0;
      an_q     <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      frame_q  <= frame_d;
      sa_q     <= sa_d;
      an_q     <= an_d;
    end
  end

  assign SA      = sa_q;
  assign AN      = an_q;
  assign DIG_IDX = idx_q;
  assign PEND    = pend_q;
  assign FRAME   = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl with NUM_DIGITS=4, PRESC_DIV=8, DEAD_CYC=2.
// The reference model tracks the position inside a frame (0..31) and the
// shadow, active and pending values as plain integers. It derives the
// expected outputs from that position arithmetically.
module tb_display_scan_ctrl;

  localparam int ND   = 4;
  localparam int PD   = 8;
  localparam int DC   = 2;
  localparam int FLEN = ND * PD;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        LOAD;
  logic [15:0] VAL;
  logic [3:0]  SA;
  logic [3:0]  AN;
  logic [1:0]  DIG_IDX;
  logic        PEND;
  logic        FRAME;

  display_scan_ctrl #(
    .NUM_DIGITS(ND),
    .PRESC_DIV (PD),
    .DEAD_CYC  (DC)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .LOAD   (LOAD),
    .VAL    (VAL),
    .SA     (SA),
    .AN     (AN),
    .DIG_IDX(DIG_IDX),
    .PEND   (PEND),
    .FRAME  (FRAME)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_pos;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  logic        m_pend;
  logic        m_frame;
  logic [3:0]  m_an;
  logic [3:0]  m_sa;
  logic [1:0]  m_idx;

  function automatic bit digit_shown(input logic [15:0] act, input int d);
`ifdef LZ_BLANK_EN
    return (d == 0) || ((act >> (4 * d)) != 16'd0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h pos=%0d", tag, obs, exp_v, m_pos);
    end
  endtask

  task automatic compare_all();
    chk4("AN", AN, m_an);
    chk4("SA", SA, m_sa);
    chk4("DIG_IDX", {2'b00, DIG_IDX}, {2'b00, m_idx});
    chk4("PEND", {3'b000, PEND}, {3'b000, m_pend});
    chk4("FRAME", {3'b000, FRAME}, {3'b000, m_frame});
    checks++;
    assert ($countones(~AN) <= 1) else begin
      failures++;
      $error("FAIL AN_ONEHOT observed=%b expected=at_most_one_low", AN);
    end
  endtask

  // One clock with the given inputs. The model advances by one cycle and
  // every output is compared 1 ns after the edge.
  task automatic step(input bit en, input bit ld, input logic [15:0] v, input bit rst);
    bit wrap;
    EN = en; LOAD = ld; VAL = v; RST = rst;
    @(posedge CLK);
    if (rst) begin
      m_pos = 0; m_shadow = 16'd0; m_active = 16'd0; m_pend = 1'b0;
      m_frame = 1'b0;
    end else begin
      wrap    = en && (m_pos == FLEN - 1);
      m_frame = wrap;
      if (wrap && m_pend) begin
        m_active = m_shadow;
        m_pend   = 1'b0;
      end
      if (ld) begin
        m_shadow = v;
        m_pend   = 1'b1;
      end
      if (en) m_pos = (m_pos + 1) % FLEN;
    end
    m_idx = 2'(m_pos / PD);
    m_sa  = 4'((m_active >> (4 * (m_pos / PD))) & 16'hF);
    m_an  = 4'b1111;
    if (!rst && en && (m_pos % PD) >= DC && digit_shown(m_active, m_pos / PD))
      m_an[m_pos / PD] = 1'b0;
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic run_to_pos(input int target);
    for (int i = 0; i < FLEN && m_pos != target; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    CLK = 1'b0; RST = 1'b1; EN = 1'b0; LOAD = 1'b0; VAL = 16'h0;
    m_pos = 0;

    // Reset state
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk4("RESET_AN", AN, 4'b1111);

    // Free-running scan without loads: blanking/drive pattern and FRAME
    run(40);

    // Mid-frame load of 4321: held until the wrap, then shown as 1,2,3,4
    step(1'b1, 1'b1, 16'h4321, 1'b0);
    chk4("PEND_AFTER_LOAD", {3'b000, PEND}, 4'b0001);
    run_to_pos(FLEN - 1);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk4("COMMIT_SA0", SA, 4'h1);
    run(PD);
    chk4("COMMIT_SA1", SA, 4'h2);
    run(40);

    // Two loads in one frame: last write wins
    step(1'b1, 1'b1, 16'h1111, 1'b0);
    run(5);
    step(1'b1, 1'b1, 16'h9876, 1'b0);
    run_to_pos(FLEN - 1);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk4("LASTWIN_SA0", SA, 4'h6);
    run(40);

    // Load exactly on the wrap edge with nothing pending
    run_to_pos(FLEN - 1);
    step(1'b1, 1'b1, 16'h5555, 1'b0);
    chk4("WRAPLOAD_SA", SA, 4'h6);
    chk4("WRAPLOAD_PEND", {3'b000, PEND}, 4'b0001);
    run(FLEN - 1);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk4("WRAPLOAD_NEXT", SA, 4'h5);
    run(10);

    // EN dropped mid-DRIVE for 10 cycles, then resumed
    run_to_pos(PD + 4);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    chk4("FROZEN_IDX", {2'b00, DIG_IDX}, 4'd1);
    run(20);

    // Reset in the middle of a slot
    run_to_pos(2 * PD + 3);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk4("MIDRST_AN", AN, 4'b1111);
    run(10);

    // Leading-zero cases (plain scan when the macro is undefined)
    step(1'b1, 1'b1, 16'h0050, 1'b0);
    run(2 * FLEN + 4);
    step(1'b1, 1'b1, 16'h0000, 1'b0);
    run(2 * FLEN + 4);

    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(7) != 0), ($urandom_range(15) == 0),
           16'($urandom), ($urandom_range(199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
